uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
// Configurable UART receiver: next generation of the fixed 8N1 receiver, with parametrised
// data width, parity and stop bits, 2-flop input synchroniser, start-glitch rejection,
// per-word parity/framing status and a show-ahead receive FIFO with ready/valid-style pop.
// Sits between the rx pad and the host/register interface.
// PARAMETERS
// CLK_FREQ    50000000  system clock frequency, Hz
// BAUD        115200    line rate; CLKDIV = CLK_FREQ/BAUD-1 (integer), HALF = CLKDIV>>1
// DATA_BITS   8         data bits per frame, legal 5..9, sent LSB first
// PARITY      0         0 none, 1 odd, 2 even
// STOP_BITS   1         1 or 2
// FIFO_DEPTH  4         receive FIFO entries, power of two, >=2
// PORTS
// clk         in   1          system clock
// rst         in   1          synchronous reset, active-low
// rx_serial   in   1          asynchronous serial line, idle high
// rd_en       in   1          pop head entry; honoured only when dout_valid=1
// dout        out  DATA_BITS  head-of-FIFO data word; 0 when FIFO empty
// dout_valid  out  1          FIFO not empty
// parity_err  out  1          parity mismatch flag of the head word; 0 when empty or PARITY=0
// frame_err   out  1          stop-bit error flag of the head word; 0 when empty
// overrun     out  1          sticky: a completed word was dropped because the FIFO was full
// clr_err     in   1          clears overrun (clear wins over a same-cycle set)
// busy        out  1          receiver FSM not in IDLE
// BEHAVIOUR
// - Reset: FSM IDLE, counters 0, synchroniser flops 1, FIFO empty, overrun 0, busy 0;
//   so dout=0, dout_valid=0, parity_err=0, frame_err=0. Partial frame discarded.
// - rx_serial passes 2 flops (rxs) before use: 2-cycle input latency.
// - Counter cntr is 16-bit, clears on every state change.
// - IDLE: rxs==0 -> START.
// - START: cntr increments; at cntr==HALF, rxs==0 -> DATA; rxs==1 -> IDLE (glitch, no word).
// - DATA: sample rxs when cntr==CLKDIV, shift in LSB first, cntr->0; after DATA_BITS
//   samples -> PARITY if PARITY!=0, else STOP.
// - PARITY: sample at cntr==CLKDIV; err = (^data ^ bit) != (PARITY==1). -> STOP.
// - STOP: sample each stop bit at cntr==CLKDIV; any 0 sets frame error.
//   On last stop sample: push {data, perr, ferr} same edge; ferr=0 -> IDLE,
//   ferr=1 -> WAIT_HIGH.
// - WAIT_HIGH: stays until rxs==1, then IDLE (a break yields exactly one word, 0, ferr=1).
// - Sampling occurs mid-bit, so the FSM is back in IDLE half a bit before stop-bit end;
//   back-to-back frames with no idle time are received without loss.
// - FIFO: show-ahead; dout_valid rises the cycle after the push edge.
//   Pop on rd_en&dout_valid; next entry visible the following cycle. rd_en when empty ignored.
// - Push when full: word dropped, overrun<=1. Push and pop on the same cycle when full:
//   both occur, no overrun. Push and pop when one entry present: count stays 1.
// - Pointers are log2(FIFO_DEPTH)-bit, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
// TESTING (CLK_FREQ=160, BAUD=10 -> CLKDIV=15, HALF=7, 16 clk/bit)
// 1 8N1, frame 0xA5 -> one push, dout=0xA5, dout_valid=1, parity_err=0, frame_err=0;
//   rd_en 1 cycle -> dout_valid=0, dout=0.
// 2 8E1, data 0x03 with parity bit 1 -> dout=0x03, parity_err=1; parity bit 0 -> parity_err=0.
// 3 8N1, line low for 20 bit times then high -> exactly one word 0x00 with frame_err=1;
//   next frame 0x5A after line high -> 0x5A, frame_err=0.
// 4 low pulse of 4 clk on idle line -> FSM returns to IDLE, busy low, no push.
// 5 FIFO_DEPTH=4, 5 frames 0x11..0x55 without reading -> FIFO holds 0x11..0x44, overrun=1;
//   clr_err -> overrun=0; repeat 5th push with same-cycle rd_en -> no overrun, head 0x22.
// 6 rst low mid-DATA of a frame -> all outputs at reset values, no word pushed;
//   subsequent clean frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a show-ahead receive FIFO.
//
// The rx line is re-timed through a two-flop synchroniser. The FSM confirms
// the start bit at mid-bit (short low glitches are rejected) and then samples
// data, optional parity and stop bits at each bit centre. Every completed word
// is pushed into the FIFO together with its parity and framing flags.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-low
//   rx_serial   asynchronous serial line, idle high
//   rd_en       pop the head entry (ignored while the FIFO is empty)
//   clr_err     clear the sticky overrun flag (wins over a same-cycle set)
//   dout        head-of-FIFO data word, 0 when empty
//   dout_valid  FIFO not empty
//   parity_err  parity flag of the head word, 0 when empty or parity disabled
//   frame_err   stop-bit flag of the head word, 0 when empty
//   overrun     sticky: a completed word was dropped because the FIFO was full
//   busy        receiver FSM not idle
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | line idle, waiting for a low level on rxs
// S_START     | counting to mid start bit; still low -> data, high -> glitch
// S_DATA      | sampling DATA_BITS data bits at bit centre, LSB first
// S_PARITY    | sampling the parity bit
// S_STOP      | sampling STOP_BITS stop bits, pushing the word on the last
// S_WAIT_HIGH | framing error seen; wait for the line to return high

module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [15:0] CLKDIV    = 16'(CLK_FREQ / BAUD - 1);
    localparam logic [15:0] HALF      = CLKDIV >> 1;
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic        HAS_PAR   = (PARITY != 0);
    localparam logic        ODD_PAR   = (PARITY == 1);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          EW        = DATA_BITS + 2;
    localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // synchroniser
    logic rx_s1;
    logic rxs;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx_serial;
            rxs   <= rx_s1;
        end
    end

    // receiver FSM
    state_t                state, state_n;
    logic [15:0]           cntr, cntr_n;
    logic [3:0]            bit_cnt, bit_n;
    logic [DATA_BITS-1:0]  shreg, shreg_n;
    logic                  perr_q, perr_n;
    logic                  ferr_q, ferr_n;
    logic                  push_req;
    logic [EW-1:0]         push_word;
    logic                  sample;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cntr    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cntr    <= cntr_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            perr_q  <= perr_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cntr_n   = cntr + 16'd1;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        perr_n   = perr_q;
        ferr_n   = ferr_q;
        push_req = 1'b0;
        sample   = (cntr == CLKDIV);

        case (state)
            S_IDLE: begin
                cntr_n = '0;
                bit_n  = '0;
                if (!rxs) begin
                    state_n = S_START;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end
            S_START: begin
                if (cntr == HALF) begin
                    // a line that is high again at mid start bit was a glitch
                    state_n = rxs ? S_IDLE : S_DATA;
                    cntr_n  = '0;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                    cntr_n  = '0;
                    if (bit_cnt == LAST_DATA) begin
                        state_n = HAS_PAR ? S_PARITY : S_STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_n  = (((^shreg) ^ rxs) != ODD_PAR);
                    state_n = S_STOP;
                    cntr_n  = '0;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                if (sample) begin
                    cntr_n = '0;
                    ferr_n = ferr_q | ~rxs;
                    if (bit_cnt == LAST_STOP) begin
                        push_req = 1'b1;
                        // a low stop bit may be a break: do not re-arm until high
                        state_n  = ferr_n ? S_WAIT_HIGH : S_IDLE;
                        bit_n    = '0;
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cntr_n = '0;
                if (rxs) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cntr_n  = '0;
                bit_n   = '0;
            end
        endcase

        push_word = {shreg, perr_q, ferr_n};
    end

    assign busy = (state != S_IDLE);

    // receive FIFO
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic [EW-1:0] head;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = rd_en & ~empty;
    // a full FIFO still accepts a word when the head leaves on the same edge
    assign do_push = push_req & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end else if (push_req && !do_push) begin
            overrun <= 1'b1;
        end
    end

    assign head       = mem[rd_ptr];
    assign dout_valid = ~empty;
    assign dout       = empty ? '0 : head[EW-1:2];
    assign parity_err = ~empty & HAS_PAR & head[1];
    assign frame_err  = ~empty & head[0];

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance A: 8N1, instance B: 8E1; both 16 clk per bit, 4-entry FIFO
    logic       rx_a = 1'b1, rd_en_a = 1'b0, clr_a = 1'b0;
    logic [7:0] dout_a;
    logic       dv_a, pe_a, fe_a, ovr_a, busy_a;
    logic       rx_b = 1'b1, rd_en_b = 1'b0, clr_b = 1'b0;
    logic [7:0] dout_b;
    logic       dv_b, pe_b, fe_b, ovr_b, busy_b;

    uart_rx_cfg #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rx_serial(rx_a), .rd_en(rd_en_a), .clr_err(clr_a),
        .dout(dout_a), .dout_valid(dv_a), .parity_err(pe_a), .frame_err(fe_a),
        .overrun(ovr_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rx_serial(rx_b), .rd_en(rd_en_b), .clr_err(clr_b),
        .dout(dout_b), .dout_valid(dv_b), .parity_err(pe_b), .frame_err(fe_b),
        .overrun(ovr_b), .busy(busy_b));

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_ovr_a = 1'b0;
    logic exp_ovr_b = 1'b0;
    logic auto_a = 1'b1, man_rd_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a word arriving at a full FIFO is lost and flags overrun
    task automatic model_push_a(input logic [7:0] d, input logic pe, input logic fe);
        if (qa.size() < 4) qa.push_back('{d, pe, fe});
        else exp_ovr_a = 1'b1;
    endtask

    task automatic model_push_b(input logic [7:0] d, input logic pe, input logic fe);
        if (qb.size() < 4) qb.push_back('{d, pe, fe});
        else exp_ovr_b = 1'b1;
    endtask

    // Word completion: 2 sync cycles + 1 detect + HALF+1 start + 16 per remaining bit
    // -> posedge 11 + 16*(data+parity+stop bits) counted from the start-bit negedge.
    task automatic frame_a(input logic [7:0] d);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    rx_a = f[i];
                    repeat (16) @(negedge clk);
                end
            end
            begin
                repeat (155) @(posedge clk);
                #1 model_push_a(d, 1'b0, 1'b0);
            end
        join
    endtask

    task automatic frame_b(input logic [7:0] d, input logic pbit);
        logic [10:0] f;
        logic        pe;
        f  = {1'b1, pbit, d, 1'b0};
        pe = ((($countones(d) + int'(pbit)) % 2) != 0);
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    rx_b = f[i];
                    repeat (16) @(negedge clk);
                end
            end
            begin
                repeat (171) @(posedge clk);
                #1 model_push_b(d, pe, 1'b0);
            end
        join
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || dv_a || dv_b) && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got qa=%0d qb=%0d expected both 0", qa.size(), qb.size());
        end
        @(negedge clk);
    endtask

    // monitor A: chooses rd_en, and on every accepted pop compares against the model
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            rd_en_a = auto_a ? ($urandom_range(0, 3) != 0) : man_rd_a;
            if (rd_en_a && dv_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_word: got %0h expected no word", dout_a);
                end else begin
                    e = qa.pop_front();
                    check("a_word", {dout_a, pe_a, fe_a}, {e.d, e.pe, e.fe});
                end
            end
        end
    end

    // monitor B
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            rd_en_b = ($urandom_range(0, 2) != 0);
            if (rd_en_b && dv_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_word: got %0h expected no word", dout_b);
                end else begin
                    e = qb.pop_front();
                    check("b_word", {dout_b, pe_b, fe_b}, {e.d, e.pe, e.fe});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_a", {dout_a, dv_a, pe_a, fe_a, ovr_a, busy_a}, 32'h0);
        check("reset_b", {dout_b, dv_b, pe_b, fe_b, ovr_b, busy_b}, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // single word, manual pop
        auto_a = 1'b0;
        frame_a(8'hA5);
        check("t1_valid", dv_a, 1'b1);
        check("t1_dout", dout_a, 8'hA5);
        @(posedge clk); #1 man_rd_a = 1'b1;
        @(posedge clk); #1 man_rd_a = 1'b0;
        @(negedge clk);
        check("t1_empty", {dout_a, dv_a}, 9'h0);
        auto_a = 1'b1;

        // 8E1 parity cases
        frame_b(8'h03, 1'b1);
        frame_b(8'h03, 1'b0);
        wait_drain();

        // break: 20 bit times low
        fork
            begin
                rx_a = 1'b0;
                repeat (320) @(negedge clk);
                rx_a = 1'b1;
            end
            begin
                repeat (155) @(posedge clk);
                #1 model_push_a(8'h00, 1'b0, 1'b1);
                repeat (20) @(negedge clk);
                check("t3_wait_high_busy", busy_a, 1'b1);
            end
        join
        repeat (20) @(negedge clk);
        check("t3_idle_after_break", busy_a, 1'b0);
        frame_a(8'h5A);
        wait_drain();

        // start glitch
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_busy_in_start", busy_a, 1'b1);
        repeat (20) @(negedge clk);
        check("t4_glitch_idle", {busy_a, dv_a}, 2'b00);

        // overrun
        auto_a = 1'b0;
        for (int i = 1; i <= 5; i++) frame_a(8'(i * 8'h11));
        check("t5_valid", dv_a, 1'b1);
        check("t5_head", dout_a, 8'h11);
        check("t5_overrun", ovr_a, exp_ovr_a);
        check("t5_model_depth", qa.size(), 4);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        exp_ovr_a = 1'b0;
        check("t5_clr", ovr_a, exp_ovr_a);
        fork
            frame_a(8'h55);
            begin
                repeat (154) @(posedge clk);
                #1 man_rd_a = 1'b1;
                @(posedge clk);
                #1 man_rd_a = 1'b0;
            end
        join
        check("t5_head_after_pop", dout_a, 8'h22);
        check("t5_no_overrun", ovr_a, exp_ovr_a);
        auto_a = 1'b1;
        wait_drain();

        // reset in the middle of the data bits
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        repeat (16) @(negedge clk);
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        check("t6_busy_before_rst", busy_a, 1'b1);
        rst = 1'b0;
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_reset_a", {dout_a, dv_a, pe_a, fe_a, ovr_a, busy_a}, 32'h0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_word", {busy_a, dv_a}, 2'b00);
        frame_a(8'h3C);
        wait_drain();

        // randomized traffic on both lines
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            frame_a(d);
            rx_a = 1'b1;
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            frame_b(d, 1'($urandom));
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        wait_drain();
        check("final_overrun_a", ovr_a, exp_ovr_a);
        check("final_overrun_b", ovr_b, exp_ovr_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
